// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the PISO serializer: FSM state encoding and word width.
package piso_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1, flags the last position.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          async_reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_terminal
);

    logic [CW-1:0] r_count;

    assign o_terminal = (r_count == CW'(WIDTH - 1));
    assign o_count    = r_count;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_terminal ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load handshake and frame markers.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    w_count;
    logic             w_terminal;
    logic             w_load;
    logic             w_shift_step;
    logic             w_head_bit;

    assign w_load       = load_valid & load_ready;
    assign w_shift_step = (r_state == SHIFT) & shift_en;
    assign w_head_bit   = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];

    bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk         (clk),
        .async_reset (async_reset),
        .i_clear     (w_load),
        .i_enable    (w_shift_step),
        .o_count     (w_count),
        .o_terminal  (w_terminal)
    );

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        ser_out      = 1'b0;
        ser_valid    = 1'b0;
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid   = 1'b1;
                ser_out     = w_head_bit;
                frame_start = (w_count == '0);
                frame_end   = w_terminal;
                // Last bit consumed: accept a follow-on word in the same edge or fall back to IDLE.
                if (shift_en && w_terminal) begin
                    load_ready = 1'b1;
                    if (!load_valid) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: the shift register is cleared on reset so no stale word can reappear after an abort.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_shreg <= '0;
        end else if (w_load) begin
            r_shreg <= data_in;
        end else if (w_shift_step) begin
            r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer: LSB-first and MSB-first instances share stimulus.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       async_reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       shift_en;

    logic load_ready, ser_out, ser_valid, frame_start, frame_end;
    logic m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_frame_end;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .shift_en    (shift_en),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk         (clk),
        .async_reset (async_reset),
        .data_in     (data_in),
        .load_valid  (load_valid),
        .load_ready  (m_load_ready),
        .shift_en    (shift_en),
        .ser_out     (m_ser_out),
        .ser_valid   (m_ser_valid),
        .frame_start (m_frame_start),
        .frame_end   (m_frame_end)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic b, input logic fs, input logic fe,
                           input logic lr);
        #1;
        check({tag, "/valid"}, ser_valid, 1'b1);
        check({tag, "/bit"},   ser_out,   b);
        check({tag, "/fs"},    frame_start, fs);
        check({tag, "/fe"},    frame_end,   fe);
        check({tag, "/ready"}, load_ready,  lr);
    endtask

    task automatic chk_idle(input string tag);
        #1;
        check({tag, "/idle_valid"}, ser_valid,   1'b0);
        check({tag, "/idle_bit"},   ser_out,     1'b0);
        check({tag, "/idle_fs"},    frame_start, 1'b0);
        check({tag, "/idle_fe"},    frame_end,   1'b0);
        check({tag, "/idle_ready"}, load_ready,  1'b1);
    endtask

    // Offer a word on the next edge from IDLE; leaves load_valid low after the load.
    task automatic load_word(input logic [7:0] w);
        data_in    = w;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        data_in    = ~w;
    endtask

    // Stream a full word with shift_en held high and expect a return to IDLE.
    task automatic stream_word(input string tag, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            chk_bit($sformatf("%s_b%0d", tag, i), w[i], i == 0, i == 7, i == 7);
            tick();
        end
        chk_idle(tag);
    endtask

    task automatic do_reset();
        async_reset = 1'b1;
        tick();
        tick();
        async_reset = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] w2;
        async_reset = 1'b1;
        data_in     = 8'h00;
        load_valid  = 1'b0;
        shift_en    = 1'b0;
        do_reset();
        chk_idle("reset");
        check("reset/msb_valid", m_ser_valid, 1'b0);

        // Single word A5, LSB first, continuous shifting.
        w = 8'hA5;
        load_word(w);
        stream_word("single", w);

        // Stall three cycles on the second bit: it stays for four cycles in total.
        load_word(w);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                shift_en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk_bit($sformatf("stall_hold%0d", s), w[1], 1'b0, 1'b0, 1'b0);
                    tick();
                end
                shift_en = 1'b1;
            end
            chk_bit($sformatf("stall_b%0d", i), w[i], i == 0, i == 7, i == 7);
            tick();
        end
        chk_idle("stall");

        // Back-to-back: 0F then F0 offered during the last bit, 16 contiguous bits.
        w  = 8'h0F;
        w2 = 8'hF0;
        load_word(w);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                data_in    = w2;
                load_valid = 1'b1;
            end
            chk_bit($sformatf("b2b_a%0d", i), w[i], i == 0, i == 7, i == 7);
            tick();
        end
        load_valid = 1'b0;
        data_in    = 8'h00;
        stream_word("b2b_b", w2);

        // MSB-first instance: 80 gives a 1 followed by seven 0s.
        load_word(8'h80);
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("msb_v%0d", i),  m_ser_valid,   1'b1);
            check($sformatf("msb_b%0d", i),  m_ser_out,     i == 0);
            check($sformatf("msb_fs%0d", i), m_frame_start, i == 0);
            check($sformatf("msb_fe%0d", i), m_frame_end,   i == 7);
            tick();
        end
        #1;
        check("msb_idle", m_ser_valid, 1'b0);

        // Reset pulse between edges during the fourth bit aborts the word at once.
        w = 8'hA5;
        load_word(w);
        for (int i = 0; i < 3; i++) begin
            chk_bit($sformatf("rst_b%0d", i), w[i], i == 0, 1'b0, 1'b0);
            tick();
        end
        chk_bit("rst_b3", w[3], 1'b0, 1'b0, 1'b0);
        #1;
        async_reset = 1'b1;
        #1;
        check("rst_async_valid", ser_valid,  1'b0);
        check("rst_async_bit",   ser_out,    1'b0);
        check("rst_async_ready", load_ready, 1'b1);
        check("rst_async_fs",    frame_start, 1'b0);
        #1;
        async_reset = 1'b0;
        w = 8'h3C;
        data_in    = w;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        stream_word("post_rst", w);

        // shift_en toggling in IDLE changes nothing.
        for (int i = 0; i < 4; i++) begin
            shift_en = i[0];
            chk_idle($sformatf("idle_shift%0d", i));
            tick();
        end

        // load_valid held high through bits 1..7 must not reload or corrupt the word.
        w = 8'hC3;
        load_word(w);
        for (int i = 0; i < 8; i++) begin
            load_valid = (i < 7);
            data_in    = 8'hFF;
            chk_bit($sformatf("ign_b%0d", i), w[i], i == 0, i == 7, i == 7);
            tick();
        end
        load_valid = 1'b0;
        chk_idle("ign_end");
        tick();
        chk_idle("ign_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1; 1 = bit 0 sent first, 0 = bit WIDTH-1 sent first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 async_reset  input  1  reset, asynchronous and active-high.
REQ-005 data_in  input  WIDTH  parallel word offered for serialization.
REQ-006 load_valid  input  1  data_in holds a word to send.
REQ-007 load_ready  output  1  serializer can accept a word this cycle.
REQ-008 shift_en  input  1  downstream consumes the current bit this cycle.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out carries a valid bit.
REQ-011 frame_start  output  1  high while the first bit of a word is presented.
REQ-012 frame_end  output  1  high while the last bit of a word is presented.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-014 A load SHALL occur on a rising edge where load_valid and load_ready are both 1; data_in SHALL be captured into a WIDTH-bit shift register.
REQ-015 In IDLE, load_ready SHALL be 1, ser_valid 0, ser_out 0, frame_start 0, frame_end 0.
REQ-016 A load from IDLE SHALL move to SHIFT, with the first bit on ser_out and ser_valid 1 in the next cycle (one-cycle latency).
REQ-017 In SHIFT, each bit SHALL remain on ser_out until a rising edge with shift_en=1, then advance by one bit position.
REQ-018 A bit counter SHALL run 0..WIDTH-1; frame_start SHALL be high when the count is 0, and frame_end SHALL be high when the count is WIDTH-1 (both high only if WIDTH were 1, which is illegal).
REQ-019 In SHIFT, load_ready SHALL be 1 only when the count is WIDTH-1 and shift_en=1 (combinational from shift_en).
REQ-020 On the last-bit edge with shift_en=1:
  - if load_valid=1, the new word SHALL load and SHIFT SHALL continue with count 0 and no idle cycle;
  - otherwise the FSM SHALL return to IDLE.
REQ-021 shift_en in IDLE SHALL be ignored.
REQ-022 load_valid outside load_ready SHALL be ignored; no word SHALL be lost or duplicated.
REQ-023 data_in changes after a load SHALL NOT affect the word being sent.
REQ-024 The bit counter SHALL wrap from WIDTH-1 to 0 only through REQ-020, never mid-word.

Reset
REQ-025 async_reset=1 SHALL immediately force IDLE, count 0, shift register 0, and every output to its IDLE value, independent of clk.
REQ-026 Reset asserted mid-word SHALL abort the word with no remaining bits emitted; the first edge after deassertion SHALL accept a new load.

Structure
REQ-027 Package piso_pkg SHALL hold the state enum (IDLE, SHIFT) and the WIDTH default constant.
REQ-028 The bit counter SHALL be a sub-module, bit_counter, with WIDTH-derived width, clear, enable, and terminal-count output.

Verification
REQ-029 Single load: WIDTH=8, LSB_FIRST=1, load 8'hA5, shift_en=1 -> ser_out 1,0,1,0,0,1,0,1 on consecutive cycles; frame_start on bit 1, frame_end on bit 8; then IDLE.
REQ-030 Stall: same word with shift_en low for 3 cycles after bit 2 -> bit 2 held 4 cycles; sequence intact.
REQ-031 Back-to-back: load 8'h0F, then 8'hF0 offered during the last bit -> 16 contiguous valid bits, no gap, frame_start on bit 9.
REQ-032 MSB-first: LSB_FIRST=0, load 8'h80 -> ser_out 1 then seven 0s.
REQ-033 Reset mid-word: async_reset pulse between clock edges during bit 4 -> outputs drop immediately to IDLE values; next load sends a complete word.
REQ-034 Ignored inputs: load_valid high during bits 1..7 and shift_en toggling in IDLE -> no extra loads and no state change.
